// File: rtl/packet_sorter_if.sv
// Stream bus for packet_sorter: framed input words, sorted output words and status.
`timescale 1ns/1ps
interface packet_sorter_if #(
  parameter int DWIDTH = 8
);
  logic [DWIDTH-1:0] data_i;
  logic              sop_i;
  logic              eop_i;
  logic              val_i;
  logic              desc_i;
  logic              ready_i;
  logic [DWIDTH-1:0] data_o;
  logic              sop_o;
  logic              eop_o;
  logic              val_o;
  logic              trunc_o;
  logic              busy_o;

  modport master (
    output data_i, sop_i, eop_i, val_i, desc_i, ready_i,
    input  data_o, sop_o, eop_o, val_o, trunc_o, busy_o
  );

  modport slave (
    input  data_i, sop_i, eop_i, val_i, desc_i, ready_i,
    output data_o, sop_o, eop_o, val_o, trunc_o, busy_o
  );
endinterface

// File: rtl/packet_sorter.sv
// Buffers one sop/eop packet, sorts it in place (odd-even transposition), streams it out.
// eop at edge E gives first val_o after E+DEPTH+1; ready_i=0 holds every output; input ignored while busy.
`timescale 1ns/1ps
module packet_sorter #(
  parameter int DWIDTH = 8,
  parameter int AWIDTH = 3
) (
  input logic            clk_i,
  input logic            arst_n_i,
  packet_sorter_if.slave bus
);
  localparam int DEPTH = 2**AWIDTH;
  localparam logic [AWIDTH:0] DEPTH_C = (AWIDTH+1)'(DEPTH);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RECV = 2'd1;
  localparam logic [1:0] ST_SORT = 2'd2;
  localparam logic [1:0] ST_SEND = 2'd3;

  logic [1:0]        state;
  logic [AWIDTH:0]   count;
  logic [AWIDTH-1:0] rd;
  logic [AWIDTH:0]   pass;
  logic              desc_q;
  logic              trunc_q;

  logic [DWIDTH-1:0] mem     [DEPTH];
  logic [DWIDTH-1:0] mem_nxt [DEPTH];

  logic              start;
  logic              wr_en;
  logic [AWIDTH-1:0] wr_idx;
  logic              last_pass;
  logic              is_last;
  logic              sending;

  assign start     = bus.val_i && bus.sop_i && (state == ST_IDLE || state == ST_RECV);
  assign wr_en     = start || (state == ST_RECV && bus.val_i && count < DEPTH_C);
  assign wr_idx    = start ? '0 : count[AWIDTH-1:0];
  // Pass index DEPTH is an idle settle cycle after the last compare pass.
  assign last_pass = (pass == DEPTH_C);
  assign is_last   = ({1'b0, rd} == count - 1'b1);
  assign sending   = (state == ST_SEND);

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      mem_nxt[i] = mem[i];
    end
    for (int i = 0; i < DEPTH-1; i++) begin
      if (i[0] == pass[0] && (AWIDTH+1)'(i+1) < count) begin
        if (desc_q ? (mem[i] < mem[i+1]) : (mem[i] > mem[i+1])) begin
          mem_nxt[i]   = mem[i+1];
          mem_nxt[i+1] = mem[i];
        end
      end
    end
  end

  // Storage is deliberately not reset; count bounds every read of it.
  always_ff @(posedge clk_i) begin
    if (state == ST_SORT && !last_pass) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= mem_nxt[i];
      end
    end else if (wr_en) begin
      mem[wr_idx] <= bus.data_i;
    end
  end

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      state   <= ST_IDLE;
      count   <= '0;
      rd      <= '0;
      pass    <= '0;
      desc_q  <= 1'b0;
      trunc_q <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_RECV: begin
          pass <= '0;
          if (start) begin
            count   <= (AWIDTH+1)'(1);
            desc_q  <= bus.desc_i;
            trunc_q <= 1'b0;
            state   <= bus.eop_i ? ST_SORT : ST_RECV;
          end else if (state == ST_RECV && bus.val_i) begin
            if (count < DEPTH_C) begin
              count <= count + 1'b1;
            end else begin
              trunc_q <= 1'b1;
            end
            if (bus.eop_i) begin
              state <= ST_SORT;
            end
          end
        end
        ST_SORT: begin
          pass <= pass + 1'b1;
          if (last_pass) begin
            state <= ST_SEND;
            rd    <= '0;
          end
        end
        ST_SEND: begin
          if (bus.ready_i) begin
            if (is_last) begin
              state <= ST_IDLE;
              rd    <= '0;
            end else begin
              rd <= rd + 1'b1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.val_o   = sending;
  assign bus.data_o  = sending ? mem[rd] : '0;
  assign bus.sop_o   = sending && (rd == '0);
  assign bus.eop_o   = sending && is_last;
  assign bus.trunc_o = sending && is_last && trunc_q;
  assign bus.busy_o  = (state == ST_SORT) || sending;
endmodule

// File: tb/tb_packet_sorter.sv
// Scoreboard bench for packet_sorter: expected words queued at stimulus, checked on each output handshake.
`timescale 1ns/1ps
module tb_packet_sorter;
  logic clk    = 1'b0;
  logic arst_n = 1'b0;
  always #5 clk = ~clk;

  packet_sorter_if #(.DWIDTH(8)) bus ();

  packet_sorter #(.DWIDTH(8), .AWIDTH(3)) dut (
    .clk_i    (clk),
    .arst_n_i (arst_n),
    .bus      (bus)
  );

  typedef struct packed {
    logic [7:0] d;
    logic       sop;
    logic       eop;
    logic       tr;
  } exp_t;

  exp_t       q[$];
  int         n_vec = 0;
  int         n_err = 0;
  logic [7:0] pkt [16];
  int         lat;

  logic       stall_prev = 1'b0;
  logic [7:0] held_d;
  logic       held_sop, held_eop;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: selection sort of the first min(n,8) words.
  task automatic push_expect(input int n, input bit d);
    logic [7:0] s [8];
    logic [7:0] t;
    int m;
    exp_t e;
    m = (n > 8) ? 8 : n;
    for (int i = 0; i < m; i++) s[i] = pkt[i];
    for (int i = 0; i < m; i++)
      for (int j = i + 1; j < m; j++)
        if (d ? (s[j] > s[i]) : (s[j] < s[i])) begin
          t = s[i]; s[i] = s[j]; s[j] = t;
        end
    for (int i = 0; i < m; i++) begin
      e.d   = s[i];
      e.sop = (i == 0);
      e.eop = (i == m - 1);
      e.tr  = (i == m - 1) && (n > 8);
      q.push_back(e);
    end
  endtask

  task automatic clear_in();
    bus.val_i  = 1'b0;
    bus.sop_i  = 1'b0;
    bus.eop_i  = 1'b0;
    bus.data_i = 8'h00;
    bus.desc_i = 1'b0;
  endtask

  task automatic send_pkt(input int n, input bit d);
    push_expect(n, d);
    for (int i = 0; i < n; i++) begin
      bus.val_i  = 1'b1;
      bus.sop_i  = (i == 0);
      bus.eop_i  = (i == n - 1);
      bus.data_i = pkt[i];
      bus.desc_i = (i == 0) ? d : ~d;
      @(posedge clk); #1;
      if (i == 0 && n > 1) chk("busy_in_recv", bus.busy_o, 0);
    end
    clear_in();
  endtask

  task automatic wait_first(output int edges);
    edges = 0;
    while (!bus.val_o && edges < 100) begin
      @(posedge clk); #1;
      edges++;
    end
    if (!bus.val_o) chk("timeout_first_val", 0, 1);
  endtask

  task automatic drain(input bit toggle, input bit junk);
    int t;
    t = 0;
    while (q.size() > 0 && t < 400) begin
      if (toggle) bus.ready_i = ~bus.ready_i;
      if (junk && q.size() > 1) begin
        bus.val_i = 1'b1; bus.sop_i = 1'b1; bus.eop_i = 1'b1; bus.data_i = 8'hEE;
      end else begin
        clear_in();
      end
      @(posedge clk); #1;
      t++;
    end
    clear_in();
    bus.ready_i = 1'b1;
    if (q.size() > 0) chk("timeout_drain", q.size(), 0);
    chk("idle_val",   bus.val_o,   0);
    chk("idle_busy",  bus.busy_o,  0);
    chk("idle_sop",   bus.sop_o,   0);
    chk("idle_eop",   bus.eop_o,   0);
    chk("idle_trunc", bus.trunc_o, 0);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (arst_n) begin
      if (stall_prev) begin
        chk("hold_val", bus.val_o, 1);
        chk("hold_dat", bus.data_o, held_d);
        chk("hold_sop", bus.sop_o, held_sop);
        chk("hold_eop", bus.eop_o, held_eop);
      end
      stall_prev = bus.val_o && !bus.ready_i;
      held_d     = bus.data_o;
      held_sop   = bus.sop_o;
      held_eop   = bus.eop_o;
      if (bus.val_o && bus.ready_i) begin
        if (q.size() == 0) begin
          chk("unexpected_word", 1, 0);
        end else begin
          e = q.pop_front();
          chk("out_dat",   bus.data_o,  e.d);
          chk("out_sop",   bus.sop_o,   e.sop);
          chk("out_eop",   bus.eop_o,   e.eop);
          chk("out_trunc", bus.trunc_o, e.tr);
        end
      end
    end else begin
      stall_prev = 1'b0;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int t;
    clear_in();
    bus.ready_i = 1'b1;
    #12;
    chk("rst_val",   bus.val_o,   0);
    chk("rst_busy",  bus.busy_o,  0);
    chk("rst_sop",   bus.sop_o,   0);
    chk("rst_eop",   bus.eop_o,   0);
    chk("rst_trunc", bus.trunc_o, 0);
    chk("rst_dat",   bus.data_o,  0);
    @(negedge clk); arst_n = 1'b1;
    @(posedge clk); #1;

    // Words without sop in IDLE must be ignored.
    bus.val_i = 1'b1; bus.eop_i = 1'b1; bus.data_i = 8'h77;
    @(posedge clk); #1;
    @(posedge clk); #1;
    clear_in();
    repeat (3) @(posedge clk);
    #1;
    chk("nosop_busy", bus.busy_o, 0);
    chk("nosop_val",  bus.val_o,  0);

    // 1: ascending, duplicates, latency
    pkt[0] = 9; pkt[1] = 3; pkt[2] = 200; pkt[3] = 3; pkt[4] = 0;
    send_pkt(5, 0);
    wait_first(lat);
    chk("latency_t1", lat, 9);
    drain(0, 0);

    // 2: descending full packet
    for (int i = 0; i < 8; i++) pkt[i] = 8'(i + 1);
    send_pkt(8, 1);
    chk("busy_after_eop", bus.busy_o, 1);
    wait_first(lat);
    drain(0, 0);

    // 3: single word
    pkt[0] = 8'h5A;
    send_pkt(1, 0);
    wait_first(lat);
    chk("latency_t3", lat, 9);
    drain(0, 0);

    // 4: truncated packet
    for (int i = 0; i < 11; i++) pkt[i] = 8'(11 - i);
    send_pkt(11, 0);
    wait_first(lat);
    drain(0, 0);

    // 5: backpressure with junk input during SORT and SEND
    pkt[0] = 50; pkt[1] = 7; pkt[2] = 7; pkt[3] = 255; pkt[4] = 1; pkt[5] = 128;
    send_pkt(6, 0);
    bus.val_i = 1'b1; bus.sop_i = 1'b1; bus.eop_i = 1'b1; bus.data_i = 8'h11;
    repeat (3) @(posedge clk);
    #1;
    clear_in();
    wait_first(lat);
    drain(1, 1);

    // 6: reset mid-SEND, then a normal packet
    pkt[0] = 5; pkt[1] = 4; pkt[2] = 3; pkt[3] = 2; pkt[4] = 1;
    send_pkt(5, 0);
    wait_first(lat);
    t = 0;
    while (q.size() > 3 && t < 100) begin
      @(posedge clk); #1;
      t++;
    end
    arst_n = 1'b0;
    #1;
    chk("arst_val",   bus.val_o,   0);
    chk("arst_busy",  bus.busy_o,  0);
    chk("arst_sop",   bus.sop_o,   0);
    chk("arst_eop",   bus.eop_o,   0);
    chk("arst_trunc", bus.trunc_o, 0);
    chk("arst_dat",   bus.data_o,  0);
    q.delete();
    #10;
    arst_n = 1'b1;
    @(posedge clk); #1;
    pkt[0] = 2; pkt[1] = 1; pkt[2] = 0;
    send_pkt(3, 0);
    wait_first(lat);
    chk("latency_t6", lat, 9);
    drain(0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
